// File: rtl/tcd_dma_reader_pkg.sv
// Shared types and arithmetic helpers for the TCD DMA reader: FSM state
// encoding, word-alignment mask and byte-to-word rounding.
package tcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    DONE
  } tcd_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int BPW        = DEF_DATA_W / 8;
  localparam int HELPER_W   = 64;

  // Mask that clears the byte-offset bits of an address for a word of 2**lg_bpw bytes.
  function automatic logic [HELPER_W-1:0] align_mask(input int lg_bpw);
    return ~((64'd1 << lg_bpw) - 64'd1);
  endfunction

  // ceil(nbytes / 2**lg_bpw) without forming nbytes + BPW - 1, so it never overflows.
  function automatic logic [HELPER_W-1:0] words_from_bytes(input logic [HELPER_W-1:0] nbytes,
                                                           input int lg_bpw);
    logic [HELPER_W-1:0] rem_mask;
    rem_mask = (64'd1 << lg_bpw) - 64'd1;
    return (nbytes >> lg_bpw) + {63'd0, |(nbytes & rem_mask)};
  endfunction

endpackage

// File: rtl/tcd_dma_reader_if.sv
// Bundle of the MMIO request, memory read and packet-stream signals around the
// TCD DMA reader; master is the reader, slave is its environment.
interface tcd_dma_reader_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NBYTES_W = 16
);

  logic [ADDR_W-1:0]   addr_in;
  logic [NBYTES_W-1:0] nbytes_in;
  logic                req_in;
  logic                ack_in;
  logic                busy_out;
  logic                done_out;
  logic                mem_enable_out;
  logic [ADDR_W-1:0]   mem_addr_out;
  logic [DATA_W-1:0]   mem_data_in;
  logic                tx_valid_out;
  logic [DATA_W-1:0]   tx_data_out;
  logic                tx_last_out;
  logic                tx_ready_in;

  modport master (
    input  addr_in, nbytes_in, req_in, ack_in, mem_data_in, tx_ready_in,
    output busy_out, done_out, mem_enable_out, mem_addr_out,
           tx_valid_out, tx_data_out, tx_last_out
  );

  modport slave (
    output addr_in, nbytes_in, req_in, ack_in, mem_data_in, tx_ready_in,
    input  busy_out, done_out, mem_enable_out, mem_addr_out,
           tx_valid_out, tx_data_out, tx_last_out
  );

endinterface

// File: rtl/tcd_dma_reader.sv
// Transfer-control engine: fetches a (base, length) buffer word by word from
// data memory and streams it out, then reports completion and awaits ack.
module tcd_dma_reader
  import tcd_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NBYTES_W    = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  tcd_dma_reader_if.master  bus
);

  localparam int BPW_L  = DATA_W / 8;
  localparam int LG_BPW = $clog2(BPW_L);

  tcd_state_t          r_state;
  tcd_state_t          w_state_next;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [NBYTES_W-1:0] r_words;
  logic [2:0]          r_lat;
  logic [DATA_W-1:0]   r_data;

  logic [ADDR_W-1:0]   w_addr_mask;
  logic [NBYTES_W-1:0] w_words_in;
  logic                w_handshake;
  logic                w_lat_expire;
  logic                w_last_word;

  assign w_addr_mask  = ADDR_W'(align_mask(LG_BPW));
  assign w_words_in   = NBYTES_W'(words_from_bytes(64'(bus.nbytes_in), LG_BPW));
  assign w_handshake  = (r_state == SEND) && bus.tx_ready_in;
  assign w_lat_expire = (r_lat <= 3'd1);
  assign w_last_word  = (r_words == NBYTES_W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_in) begin
          w_state_next = (w_words_in == '0) ? DONE : FETCH;
        end
      end
      FETCH: w_state_next = WAIT;
      WAIT: begin
        if (w_lat_expire) begin
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (bus.tx_ready_in) begin
          w_state_next = w_last_word ? DONE : FETCH;
        end
      end
      DONE: begin
        if (bus.ack_in) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: address/word counters, latency countdown and the captured read word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cur_addr <= '0;
      r_words    <= '0;
      r_lat      <= '0;
      r_data     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_in) begin
            r_cur_addr <= bus.addr_in & w_addr_mask;
            r_words    <= w_words_in;
          end
        end
        FETCH: begin
          r_lat <= 3'(MEM_LATENCY);
        end
        WAIT: begin
          r_lat <= r_lat - 3'd1;
          if (w_lat_expire) begin
            r_data <= bus.mem_data_in;
          end
        end
        SEND: begin
          if (w_handshake) begin
            r_words    <= r_words - NBYTES_W'(1);
            r_cur_addr <= r_cur_addr + ADDR_W'(BPW_L);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode straight from registered state, so an async reset clears them at once.
  assign bus.busy_out       = (r_state != IDLE);
  assign bus.done_out       = (r_state == DONE);
  assign bus.mem_enable_out = (r_state == FETCH);
  assign bus.mem_addr_out   = r_cur_addr;
  assign bus.tx_valid_out   = (r_state == SEND);
  assign bus.tx_data_out    = r_data;
  assign bus.tx_last_out    = (r_state == SEND) && w_last_word;

endmodule

// File: tb/tb_tcd_dma_reader.sv
// Directed, table-driven bench for tcd_dma_reader with a one-cycle memory model
// and a stream monitor that checks backpressure stability.
module tb_tcd_dma_reader;
  import tcd_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] nbytes;
    int          exp_words;
    logic [31:0] exp_first;
    bit          stall;
    bit          glitch;
    string       name;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  tcd_dma_reader_if #(.ADDR_W(32), .DATA_W(32), .NBYTES_W(16)) bus ();

  tcd_dma_reader #(
    .ADDR_W(32), .DATA_W(32), .NBYTES_W(16), .MEM_LATENCY(1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [31:0] tx_data_q[$];
  logic        tx_last_q[$];
  int          tx_cyc_q[$];

  logic        ready_drv  = 1'b1;
  bit          stall_all  = 1'b0;
  int          stall_left = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  vec_t vecs[8];

  assign bus.tx_ready_in = ready_drv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0000_00A0;
      32'h0000_0104: return 32'h0000_00A1;
      32'h0000_0108: return 32'h0000_00A2;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Memory with one cycle of read latency.
  always @(posedge clock) begin
    if (bus.mem_enable_out) bus.mem_data_in <= mem_word(bus.mem_addr_out);
  end

  // Monitor: record reads and handshakes, check stall stability, then drive tx_ready_in.
  always @(negedge clock) begin
    logic v;
    logic r;
    v = bus.tx_valid_out;
    r = bus.tx_ready_in;
    if (bus.mem_enable_out) begin
      rd_addr_q.push_back(bus.mem_addr_out);
      rd_cyc_q.push_back(cyc);
    end
    if (v) check("no_fetch_while_valid", 64'(bus.mem_enable_out), 64'd0);
    if (prev_stall && v) begin
      check("stall_data_stable", 64'(bus.tx_data_out), 64'(prev_data));
      check("stall_last_stable", 64'(bus.tx_last_out), 64'(prev_last));
    end
    if (v && r) begin
      tx_data_q.push_back(bus.tx_data_out);
      tx_last_q.push_back(bus.tx_last_out);
      tx_cyc_q.push_back(cyc);
    end
    prev_stall = v && !r;
    prev_data  = bus.tx_data_out;
    prev_last  = bus.tx_last_out;
    if (stall_all) begin
      ready_drv = 1'b0;
    end else if (stall_left > 0 && tx_data_q.size() == 1) begin
      if (v && !r) stall_left--;
      ready_drv = (stall_left == 0);
    end else begin
      ready_drv = 1'b1;
    end
  end

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_xfer(input vec_t v);
    int  busy_cyc;
    int  done_cyc;
    bit  ok;
    logic [31:0] exp_a;
    rd_addr_q.delete(); rd_cyc_q.delete();
    tx_data_q.delete(); tx_last_q.delete(); tx_cyc_q.delete();
    stall_left = v.stall ? 5 : 0;
    @(negedge clock);
    bus.addr_in = v.addr; bus.nbytes_in = v.nbytes; bus.req_in = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (bus.busy_out) begin ok = 1'b1; break; end
    end
    check({v.name, "_accept"}, 64'(ok), 64'd1);
    busy_cyc = cyc;
    bus.req_in = 1'b0; bus.addr_in = 32'hDEAD_BEEF; bus.nbytes_in = 16'h0040;
    if (v.glitch) begin
      @(negedge clock); bus.req_in = 1'b1;
      @(negedge clock); bus.req_in = 1'b0; bus.ack_in = 1'b1;
      @(negedge clock); bus.ack_in = 1'b0;
    end
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (bus.done_out) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    done_cyc = cyc;
    check({v.name, "_done_seen"}, 64'(ok), 64'd1);
    if (!ok) begin
      pulse_reset();
      return;
    end
    check({v.name, "_read_count"}, 64'(rd_addr_q.size()), 64'(v.exp_words));
    check({v.name, "_word_count"}, 64'(tx_data_q.size()), 64'(v.exp_words));
    for (int i = 0; i < v.exp_words; i++) begin
      exp_a = v.exp_first + 32'(4 * i);
      if (i < rd_addr_q.size()) begin
        check({v.name, "_rd_addr"}, 64'(rd_addr_q[i]), 64'(exp_a));
        if (!v.stall) check({v.name, "_rd_cycle"}, 64'(rd_cyc_q[i]), 64'(busy_cyc + 3 * i));
      end
      if (i < tx_data_q.size()) begin
        check({v.name, "_tx_data"}, 64'(tx_data_q[i]), 64'(mem_word(exp_a)));
        check({v.name, "_tx_last"}, 64'(tx_last_q[i]), 64'(i == v.exp_words - 1));
        if (!v.stall) check({v.name, "_tx_cycle"}, 64'(tx_cyc_q[i]), 64'(busy_cyc + 2 + 3 * i));
      end
    end
    if (v.exp_words == 0)
      check({v.name, "_done_cycle"}, 64'(done_cyc), 64'(busy_cyc));
    else if (tx_cyc_q.size() > 0)
      check({v.name, "_done_cycle"}, 64'(done_cyc), 64'(tx_cyc_q[tx_cyc_q.size() - 1] + 1));
    @(negedge clock); bus.ack_in = 1'b1;
    @(negedge clock); bus.ack_in = 1'b0;
    check({v.name, "_done_after_ack"}, 64'(bus.done_out), 64'd0);
    check({v.name, "_busy_after_ack"}, 64'(bus.busy_out), 64'd0);
    repeat (2) @(negedge clock);
    check({v.name, "_stays_idle"}, 64'(bus.busy_out), 64'd0);
    $display("xfer %s addr=0x%08h nbytes=%0d words=%0d reads=%0d", v.name, v.addr, v.nbytes,
             tx_data_q.size(), rd_addr_q.size());
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},     64'(bus.busy_out),       64'd0);
    check({tag, "_done"},     64'(bus.done_out),       64'd0);
    check({tag, "_mem_en"},   64'(bus.mem_enable_out), 64'd0);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr_out),   64'd0);
    check({tag, "_tx_valid"}, 64'(bus.tx_valid_out),   64'd0);
    check({tag, "_tx_data"},  64'(bus.tx_data_out),    64'd0);
    check({tag, "_tx_last"},  64'(bus.tx_last_out),    64'd0);
  endtask

  initial begin
    bit ok;
    bus.req_in = 1'b0; bus.ack_in = 1'b0;
    bus.addr_in = '0;  bus.nbytes_in = '0;

    vecs[0] = '{32'h0000_0100, 16'd12, 3, 32'h0000_0100, 1'b0, 1'b0, "basic"};
    vecs[1] = '{32'h0000_0103, 16'd5,  2, 32'h0000_0100, 1'b0, 1'b0, "round_align"};
    vecs[2] = '{32'h0000_0200, 16'd0,  0, 32'h0000_0200, 1'b0, 1'b0, "zero_len"};
    vecs[3] = '{32'h0000_0300, 16'd16, 4, 32'h0000_0300, 1'b1, 1'b0, "backpressure"};
    vecs[4] = '{32'h0000_0400, 16'd16, 4, 32'h0000_0400, 1'b0, 1'b1, "ignored_inputs"};
    vecs[5] = '{32'hFFFF_FFFC, 16'd8,  2, 32'hFFFF_FFFC, 1'b0, 1'b0, "addr_wrap"};
    vecs[6] = '{32'h0000_0500, 16'd1,  1, 32'h0000_0500, 1'b0, 1'b0, "single_byte"};
    vecs[7] = '{32'h0000_0602, 16'd7,  2, 32'h0000_0600, 1'b0, 1'b0, "seven_bytes"};

    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b1;
    check("words_ffff", words_from_bytes(64'h0000_FFFF, 2), 64'h0000_4000);

    for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

    // Abort a transfer with reset dropped between clock edges while parked in SEND.
    stall_all = 1'b1;
    @(negedge clock);
    bus.addr_in = 32'h0000_0700; bus.nbytes_in = 16'd8; bus.req_in = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus.busy_out) bus.req_in = 1'b0;
      if (bus.tx_valid_out) begin ok = 1'b1; break; end
    end
    bus.req_in = 1'b0;
    check("abort_reached_send", 64'(ok), 64'd1);
    #2 reset = 1'b0;
    #1 check_outputs_zero("async_reset");
    @(negedge clock);
    stall_all = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("post_reset_busy",  64'(bus.busy_out),     64'd0);
      check("post_reset_done",  64'(bus.done_out),     64'd0);
      check("post_reset_valid", 64'(bus.tx_valid_out), 64'd0);
    end
    $display("async reset abort checked");
    run_xfer(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcd_dma_reader.md
Name: tcd_dma_reader

Overview:
- Transfer-control engine sitting directly downstream of the MMIO decoder's TCD port.
- Accepts a (base address, byte count) transfer request from MMIO and fetches the buffer word by word from data memory.
- Streams the words to the packet sender over a valid/ready handshake.
- Reports completion back to MMIO and waits for an acknowledge before accepting the next request.

Parameters:
- ADDR_W, 32: memory address width.
- DATA_W, 32: memory/stream word width; bytes per word BPW = DATA_W/8.
- NBYTES_W, 16: width of the transfer byte count.
- MEM_LATENCY, 1: cycles from mem_enable_out high to mem_data_in valid; legal range 1..4.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr_in  in  ADDR_W  transfer base byte address from MMIO.
- nbytes_in  in  NBYTES_W  transfer length in bytes from MMIO.
- req_in  in  1  transfer request from MMIO, level.
- ack_in  in  1  completion acknowledge from MMIO.
- busy_out  out  1  high from request accept until return to IDLE.
- done_out  out  1  transfer complete, held until acknowledged.
- mem_enable_out  out  1  memory read strobe, one cycle per word.
- mem_addr_out  out  ADDR_W  word-aligned read address.
- mem_data_in  in  DATA_W  memory read data.
- tx_valid_out  out  1  stream word valid.
- tx_data_out  out  DATA_W  stream word.
- tx_last_out  out  1  marks final word of the transfer.
- tx_ready_in  in  1  downstream ready.

Behaviour:
- Reset (reset low, async): state IDLE. All outputs 0: busy_out, done_out, mem_enable_out, mem_addr_out, tx_valid_out, tx_data_out, tx_last_out. Word counter and latency counter cleared.
- Reset asserted mid-transfer aborts immediately. No partial word is emitted after release, and done_out is not raised for the aborted transfer.
- FSM states: IDLE, FETCH, WAIT, SEND, DONE.
- IDLE:
  - On req_in=1 at a clock edge: latch cur_addr = addr_in with the low log2(BPW) bits cleared.
  - Latch words = ceil(nbytes_in/BPW), computed in NBYTES_W bits with no overflow (0xFFFF -> 0x4000 for DATA_W=32).
  - Set busy_out=1. If words==0 go to DONE, else go to FETCH.
- FETCH: one cycle. mem_enable_out=1, mem_addr_out=cur_addr. Go to WAIT; the latency counter is loaded with MEM_LATENCY.
- WAIT: mem_enable_out=0. The counter decrements. In the cycle the count reaches 0, register mem_data_in into tx_data_out and go to SEND.
  - Net effect: data is sampled exactly MEM_LATENCY cycles after the FETCH cycle.
- SEND:
  - tx_valid_out=1. tx_last_out=1 iff words==1.
  - tx_data_out and tx_last_out are held stable while tx_ready_in=0. There is no timeout.
  - On tx_valid_out and tx_ready_in both high: words -= 1, cur_addr += BPW (wraps modulo 2^ADDR_W).
  - Next state is DONE if words reaches 0, else FETCH.
  - tx_valid_out drops the cycle after the handshake.
- Throughput: one word per (2 + MEM_LATENCY) cycles with tx_ready_in held high.
- DONE: done_out=1, busy_out=1. On ack_in=1 go to IDLE: done_out and busy_out go 0 the next cycle.
- A request accepted in IDLE on the same cycle ack_in is seen is impossible, because DONE always returns to IDLE first. A new req_in is therefore accepted no earlier than one cycle after the ack.
- req_in while not in IDLE is ignored; MMIO must hold req_in until busy_out rises.
- ack_in outside DONE is ignored.
- Changes to addr_in and nbytes_in after accept have no effect.
- tx_ready_in high while tx_valid_out is low has no effect.

Decomposition:
- Shared package tcd_pkg holds:
  - the state enum tcd_state_t {IDLE, FETCH, WAIT, SEND, DONE};
  - localparam BPW and the address-alignment mask function;
  - word-count arithmetic helper words_from_bytes(nbytes).
- Top module holds the FSM and counters.
- No sub-module is needed; the latency counter is inline.

Test Plan:
- Basic transfer, MEM_LATENCY=1, tx_ready_in tied high:
  - Stimulus: req addr=0x100, nbytes=12; memory holds 0xA0,0xA1,0xA2 at 0x100/0x104/0x108.
  - Required: three words 0xA0,0xA1,0xA2 in order; tx_last_out only on 0xA2; mem_addr_out sequence 0x100,0x104,0x108; one word per 3 cycles; done_out rises the cycle after the last handshake.
- Rounding and alignment: addr=0x103, nbytes=5.
  - Required: reads at 0x100 and 0x104; exactly 2 words; last on the second.
- Zero length: nbytes=0.
  - Required: no mem_enable_out pulse and no tx_valid_out; done_out=1 one cycle after accept; ack_in -> done_out=0 and busy_out=0 next cycle.
- Backpressure:
  - Stimulus: tx_ready_in low for 5 cycles during word 2 of a 4-word transfer.
  - Required: tx_data_out and tx_last_out stable; no further mem_enable_out until the handshake; all 4 words delivered intact.
- Ignored inputs:
  - Stimulus: req_in pulse and ack_in pulse mid-transfer, then address wrap with addr=0xFFFFFFFC, nbytes=8.
  - Required: the mid-transfer pulses have no effect; reads at 0xFFFFFFFC then 0x00000000.
- Async reset:
  - Stimulus: reset low in SEND between clock edges.
  - Required: all outputs 0 immediately (no clock edge needed); after release the engine is IDLE with done_out=0; a new request is then accepted normally.
